rotary_event_queue: RTL and testbench
=====================================

Name: rotary_event_queue

Overview:
- Sits directly downstream of the rotary encoder quadrature decoder.
- Captures each encoder update as an event of {value, direction} into a small FIFO.
- Exposes the FIFO to a CSR/soft-CPU reader over a valid/ready pop interface.
- Tracks overflow and drops, and raises a level interrupt so software never polls the raw 5-bit count.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- ENC_W, 5, width of encoder value.
- DETENT_ONLY, 1, 1 = queue only when value differs from last queued value; 0 = queue every update pulse.
- DROP_W, 8, width of saturating drop counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enc_value  in  ENC_W  encoder count (dout of decoder)
- enc_direction  in  1  1 = increment, 0 = decrement
- enc_update  in  1  one-cycle pulse, per quadrature edge
- rd_valid  out  1  head event available
- rd_ready  in  1  consumer accepts head
- rd_value  out  ENC_W  head event value
- rd_direction  out  1  head event direction
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when an event is dropped
- clear_overflow  in  1  pulse; clears overflow and drop_count
- drop_count  out  DROP_W  saturating count of dropped events
- irq_enable  in  1  interrupt mask
- irq  out  1  registered interrupt

Behaviour:
- Reset: rd_valid=0, level=0, overflow=0, drop_count=0, irq=0, pointers=0, first_flag=1. rd_value/rd_direction are don't-care while rd_valid=0.
- Capture timing: the decoder registers value/direction on the edge ending the update cycle. The block therefore registers enc_update into upd_d and samples enc_value/enc_direction in the cycle where upd_d=1, i.e. one cycle after the pulse.
- Qualify: cand = upd_d & (DETENT_ONLY==0 | first_flag | enc_value != last_value).
  - On cand, last_value <= enc_value and first_flag <= 0, even if the event is dropped.
- Push: push = cand & (!full | pop).
  - Full with a simultaneous pop: the push is accepted and level is unchanged.
- Drop: cand & full & !pop.
  - Event discarded, overflow <= 1.
  - drop_count <= drop_count+1, saturating at all-ones.
- Pop: pop = rd_valid & rd_ready. Head advances on the clock edge. The next entry appears in the following cycle, or rd_valid falls if the FIFO becomes empty.
- Latency:
  - Push to rd_valid is 1 cycle, so enc_update to rd_valid is 2 cycles.
  - No combinational path from enc_* to rd_*.
- Empty with a simultaneous push: rd_valid rises next cycle. There is no same-cycle bypass.
- Level: +1 on push only, -1 on pop only, unchanged on both. Level never exceeds DEPTH.
- Pointers: width $clog2(DEPTH), natural wrap. full = (level==DEPTH), empty = (level==0).
- clear_overflow in the same cycle as a drop: set wins. overflow=1 and drop_count=1 afterwards.
- irq <= irq_enable & (rd_valid_next | overflow_next), computed from next-state values.
- Reset mid-operation:
  - All queued events are discarded and first_flag=1.
  - An enc_update pulse coinciding with reset is ignored; upd_d is cleared.
- The stable rd_* contract applies: while rd_valid=1 & rd_ready=0, rd_value/rd_direction hold.

Decomposition:
- Package rotary_pkg: ENC_W default constant, and the event typedef {direction, value} (ENC_W+1 bits).
- One sub-module, rotary_event_fifo: storage array, pointers, level, full/empty, and the push/pop-when-full rule.
- The top handles capture delay, detent qualification, overflow/drop tracking and irq.

Test Plan:
- Single event: reset; value=3, direction=1, pulse enc_update at cycle 10 -> rd_valid=1 at cycle 12, rd_value=3, rd_direction=1, level=1, irq=1 with irq_enable=1.
- Detent filtering: DETENT_ONLY=1; four pulses with value 4,4,4,5 -> exactly two events queued (4 then 5). With DETENT_ONLY=0 -> four events queued.
- Overflow: rd_ready=0; 10 distinct updates into DEPTH=8 -> level=8, overflow=1, drop_count=2, and the first 8 values pop back in order.
- Full with simultaneous push and pop: fill to 8; hold rd_ready=1 while a push arrives -> level stays 8, no drop, and the new value is last out.
- Clear vs drop: clear_overflow asserted in the same cycle as a drop -> overflow=1, drop_count=1. A later clear alone -> 0/0.
- Reset mid-stream: 5 events queued, reset for 1 cycle coinciding with an enc_update -> rd_valid=0, level=0, irq=0. The next update with value 5 (equal to the pre-reset last value) is queued because first_flag=1.

Source files
------------

// File: rtl/rotary_event_queue_pkg.sv
// Shared definitions for the rotary encoder event queue: default widths and
// the packed event layout {direction, value} used by the queue storage.
package rotary_pkg;

   localparam int ENC_W_DEFAULT = 5;

   typedef struct packed {
      logic                     direction;
      logic [ENC_W_DEFAULT-1:0] value;
   } rot_event_t;

   localparam int EVENT_W_DEFAULT = $bits(rot_event_t);

endpackage

// File: rtl/rotary_event_fifo.sv
// Small synchronous FIFO holding encoder events; a push into a full FIFO is
// accepted only when the head is popped in the same cycle.
module rotary_event_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 6,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head_data,
   output logic [LVL_W-1:0] level,
   output logic [LVL_W-1:0] level_next,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (level == LVL_W'(DEPTH));
   assign empty     = (level == '0);
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem[rd_ptr];

   always_comb begin
      level_next = level;
      if (do_push && !do_pop) begin
         level_next = level + LVL_W'(1);
      end else if (do_pop && !do_push) begin
         level_next = level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_next;
      end
   end

   // When full, wr_ptr equals rd_ptr, so a push+pop overwrites the slot being retired.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rotary_event_queue.sv
// Queues {value, direction} events from the quadrature decoder for a CSR
// reader, with detent filtering, sticky overflow, drop counting and an irq.
module rotary_event_queue
   import rotary_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int ENC_W       = ENC_W_DEFAULT,
   parameter bit DETENT_ONLY = 1'b1,
   parameter int DROP_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ENC_W-1:0]       enc_value,
   input  logic                   enc_direction,
   input  logic                   enc_update,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [ENC_W-1:0]       rd_value,
   output logic                   rd_direction,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   clear_overflow,
   output logic [DROP_W-1:0]      drop_count,
   input  logic                   irq_enable,
   output logic                   irq
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              upd_d;
   logic              first_flag;
   logic [ENC_W-1:0]  last_value;
   logic              cand;
   logic              push;
   logic              pop;
   logic              drop;
   logic              full;
   logic              empty;
   logic [LVL_W-1:0]  level_next;
   logic              overflow_next;
   logic [DROP_W-1:0] drop_count_next;

   // The decoder's value settles one cycle after its update pulse, hence sampling on upd_d.
   assign cand = upd_d & (!DETENT_ONLY | first_flag | (enc_value != last_value));
   assign pop  = rd_valid & rd_ready;
   assign push = cand & (~full | pop);
   assign drop = cand & full & ~pop;
   assign rd_valid = ~empty;

   rotary_event_fifo #(
      .DEPTH (DEPTH),
      .W     (ENC_W + 1)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  ({enc_direction, enc_value}),
      .pop        (pop),
      .head_data  ({rd_direction, rd_value}),
      .level      (level),
      .level_next (level_next),
      .full       (full),
      .empty      (empty)
   );

   // A drop in the same cycle as a clear wins: the count restarts at one.
   always_comb begin
      overflow_next   = overflow;
      drop_count_next = drop_count;
      if (clear_overflow) begin
         overflow_next   = 1'b0;
         drop_count_next = '0;
      end
      if (drop) begin
         overflow_next = 1'b1;
         if (drop_count_next != '1) drop_count_next = drop_count_next + DROP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upd_d      <= 1'b0;
         first_flag <= 1'b1;
         last_value <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         irq        <= 1'b0;
      end else begin
         upd_d <= enc_update;
         if (cand) begin
            last_value <= enc_value;
            first_flag <= 1'b0;
         end
         overflow   <= overflow_next;
         drop_count <= drop_count_next;
         irq        <= irq_enable & ((level_next != '0) | overflow_next);
      end
   end

endmodule

// File: tb/tb_rotary_event_queue.sv
// Directed bench for rotary_event_queue: a detent-filtering instance (dut) and
// an every-update instance (dut_all) share the same stimulus.
module tb_rotary_event_queue;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] enc_value = '0;
   logic       enc_direction = 1'b0;
   logic       enc_update = 1'b0;
   logic       rd_ready = 1'b0;
   logic       clear_overflow = 1'b0;
   logic       irq_enable = 1'b1;

   logic       rd_valid, rd_direction, overflow, irq;
   logic [4:0] rd_value;
   logic [3:0] level;
   logic [7:0] drop_count;

   logic       b_rd_valid, b_rd_direction, b_overflow, b_irq;
   logic [4:0] b_rd_value;
   logic [3:0] b_level;
   logic [7:0] b_drop_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rotary_event_queue #(.DEPTH(8), .ENC_W(5), .DETENT_ONLY(1'b1), .DROP_W(8)) dut (
      .clk (clk), .reset (reset), .enc_value (enc_value), .enc_direction (enc_direction),
      .enc_update (enc_update), .rd_valid (rd_valid), .rd_ready (rd_ready),
      .rd_value (rd_value), .rd_direction (rd_direction), .level (level),
      .overflow (overflow), .clear_overflow (clear_overflow), .drop_count (drop_count),
      .irq_enable (irq_enable), .irq (irq)
   );

   rotary_event_queue #(.DEPTH(8), .ENC_W(5), .DETENT_ONLY(1'b0), .DROP_W(8)) dut_all (
      .clk (clk), .reset (reset), .enc_value (enc_value), .enc_direction (enc_direction),
      .enc_update (enc_update), .rd_valid (b_rd_valid), .rd_ready (rd_ready),
      .rd_value (b_rd_value), .rd_direction (b_rd_direction), .level (b_level),
      .overflow (b_overflow), .clear_overflow (clear_overflow), .drop_count (b_drop_count),
      .irq_enable (irq_enable), .irq (b_irq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One decoder update: pulse for a cycle, then hold the value through the sample cycle.
   task automatic applyStimulus(input logic [4:0] v, input logic d);
      enc_update    = 1'b1;
      enc_value     = v;
      enc_direction = d;
      step();
      enc_update = 1'b0;
      step();
   endtask

   task automatic popOne();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      reset = 1'b0;
      checkOutput("reset_rd_valid", 32'(rd_valid), 0);
      checkOutput("reset_level", 32'(level), 0);
      checkOutput("reset_overflow", 32'(overflow), 0);
      checkOutput("reset_drop_count", 32'(drop_count), 0);
      checkOutput("reset_irq", 32'(irq), 0);

      // Single event and its latency
      enc_update = 1'b1; enc_value = 5'd3; enc_direction = 1'b1;
      step();
      enc_update = 1'b0;
      checkOutput("single_not_yet_valid", 32'(rd_valid), 0);
      step();
      checkOutput("single_rd_valid", 32'(rd_valid), 1);
      checkOutput("single_rd_value", 32'(rd_value), 3);
      checkOutput("single_rd_direction", 32'(rd_direction), 1);
      checkOutput("single_level", 32'(level), 1);
      checkOutput("single_irq", 32'(irq), 1);
      popOne();
      checkOutput("single_pop_rd_valid", 32'(rd_valid), 0);
      checkOutput("single_pop_level", 32'(level), 0);
      checkOutput("single_pop_irq", 32'(irq), 0);

      // Detent filtering: 4,4,4,5
      applyStimulus(5'd4, 1'b1);
      applyStimulus(5'd4, 1'b1);
      applyStimulus(5'd4, 1'b1);
      applyStimulus(5'd5, 1'b1);
      checkOutput("detent_level", 32'(level), 2);
      checkOutput("every_update_level", 32'(b_level), 4);
      checkOutput("detent_head0", 32'(rd_value), 4);
      popOne();
      checkOutput("detent_head1", 32'(rd_value), 5);
      popOne();
      checkOutput("detent_drained", 32'(rd_valid), 0);
      checkOutput("every_update_after_two_pops", 32'(b_level), 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("detent_reset_level", 32'(b_level), 0);

      // Overflow: 10 distinct updates into 8 entries
      for (int i = 0; i < 10; i++) applyStimulus(5'(i + 1), i[0]);
      checkOutput("ovf_level", 32'(level), 8);
      checkOutput("ovf_overflow", 32'(overflow), 1);
      checkOutput("ovf_drop_count", 32'(drop_count), 2);
      checkOutput("ovf_irq", 32'(irq), 1);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("ovf_pop%0d_value", i), 32'(rd_value), 32'(i + 1));
         checkOutput($sformatf("ovf_pop%0d_dir", i), 32'(rd_direction), 32'(i[0]));
         popOne();
      end
      checkOutput("ovf_drained", 32'(rd_valid), 0);
      checkOutput("ovf_irq_sticky", 32'(irq), 1);

      // Clear in the same cycle as a drop
      for (int i = 0; i < 8; i++) applyStimulus(5'(11 + i), 1'b1);
      checkOutput("refill_level", 32'(level), 8);
      enc_update = 1'b1; enc_value = 5'd19; enc_direction = 1'b1;
      step();
      enc_update = 1'b0;
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      checkOutput("clr_drop_overflow", 32'(overflow), 1);
      checkOutput("clr_drop_count", 32'(drop_count), 1);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      checkOutput("clr_alone_overflow", 32'(overflow), 0);
      checkOutput("clr_alone_drop_count", 32'(drop_count), 0);
      checkOutput("clr_alone_irq", 32'(irq), 1);

      // Full with simultaneous push and pop
      enc_update = 1'b1; enc_value = 5'd20; enc_direction = 1'b0;
      step();
      enc_update = 1'b0;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checkOutput("fullpp_level", 32'(level), 8);
      checkOutput("fullpp_overflow", 32'(overflow), 0);
      checkOutput("fullpp_drop_count", 32'(drop_count), 0);
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("fullpp_pop%0d_value", i), 32'(rd_value), 32'(12 + i));
         popOne();
      end
      checkOutput("fullpp_last_value", 32'(rd_value), 20);
      checkOutput("fullpp_last_dir", 32'(rd_direction), 0);
      popOne();
      checkOutput("fullpp_drained", 32'(rd_valid), 0);
      checkOutput("fullpp_irq", 32'(irq), 0);

      // Reset mid-stream coinciding with an update pulse
      for (int i = 0; i < 5; i++) applyStimulus(5'(i + 1), 1'b1);
      checkOutput("mid_level", 32'(level), 5);
      reset = 1'b1; enc_update = 1'b1; enc_value = 5'd9;
      step();
      reset = 1'b0; enc_update = 1'b0;
      checkOutput("mid_reset_rd_valid", 32'(rd_valid), 0);
      checkOutput("mid_reset_level", 32'(level), 0);
      checkOutput("mid_reset_irq", 32'(irq), 0);
      step();
      checkOutput("mid_reset_pulse_ignored", 32'(level), 0);
      applyStimulus(5'd5, 1'b1);
      checkOutput("mid_first_rd_valid", 32'(rd_valid), 1);
      checkOutput("mid_first_value", 32'(rd_value), 5);
      checkOutput("mid_first_level", 32'(level), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
